// File: rtl/adder_tree_acc_pkg.sv
// Shared neuron-datapath package: fixed-point constants, clog2 and the
// saturating narrow-down used at the accumulator output.
package ann_pkg;

    localparam int MAXW     = 128;
    localparam int FX_FRAC  = 24;
    localparam logic signed [31:0] FX_ONE = 32'sd1 <<< FX_FRAC;
    localparam logic signed [31:0] FX_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] FX_MIN = 32'sh8000_0000;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Caller truncates the result to dw bits; in wrap mode the low bits are already correct.
    function automatic logic signed [MAXW-1:0] saturate(
        input  logic signed [MAXW-1:0] value,
        input  int                     dw,
        input  bit                     doSat,
        output logic                   overflow
    );
        logic signed [MAXW-1:0] maxV;
        logic signed [MAXW-1:0] minV;
        maxV = {{(MAXW-1){1'b0}}, 1'b1} <<< (dw - 1);
        maxV = maxV - MAXW'(1);
        minV = ~maxV;
        overflow = (value > maxV) || (value < minV);
        if (doSat && (value > maxV)) return maxV;
        if (doSat && (value < minV)) return minV;
        return value;
    endfunction

endpackage

// File: rtl/adder_tree_acc_level.sv
// One registered level of the adder tree: pairwise signed adds that widen
// each sum by one bit, with the valid/last sideband delayed alongside.
module adder_level_pipe #(
    parameter  int NIN_LVL = 2,
    parameter  int W       = 32,
    localparam int NOUT    = (NIN_LVL + 1) / 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic                    last_i,
    input  logic [NIN_LVL*W-1:0]    data_i,
    output logic                    valid_o,
    output logic                    last_o,
    output logic [NOUT*(W+1)-1:0]   data_o
);

    logic [NOUT*(W+1)-1:0] sum_d;
    logic [NOUT*(W+1)-1:0] data_q;
    logic                  valid_q;
    logic                  last_q;

    for (genvar j = 0; j < NOUT; j++) begin : gPair
        logic signed [W-1:0] laneA;
        assign laneA = data_i[2*j*W +: W];
        if (2*j + 1 < NIN_LVL) begin : gTwo
            logic signed [W-1:0] laneB;
            assign laneB = data_i[(2*j+1)*W +: W];
            assign sum_d[j*(W+1) +: (W+1)] = (W+1)'(laneA) + (W+1)'(laneB);
        end else begin : gOne
            assign sum_d[j*(W+1) +: (W+1)] = (W+1)'(laneA);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            data_q  <= sum_d;
            valid_q <= valid_i;
            last_q  <= last_i;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;

endmodule

// File: rtl/adder_tree_acc.sv
// Pipelined NIN-lane signed adder tree feeding a packet accumulator with a
// saturating (or wrapping) registered output.
module adder_tree_acc
    import ann_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int frac      = 24,
    parameter int NIN       = 4,
    parameter int ACC_GUARD = 8,
    parameter int SAT       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [NIN*DWIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DWIDTH-1:0]     out_data,
    output logic                  out_sat
);

    localparam int L    = (clog2(NIN) < 1) ? 1 : clog2(NIN);
    localparam int PADN = 1 << L;
    localparam int TW   = DWIDTH + L;
    localparam int AW   = TW + ACC_GUARD;

    if (NIN < 1) begin : gBadNin
        $error("adder_tree_acc: NIN must be at least 1");
    end
    if (frac < 0 || frac >= DWIDTH) begin : gBadFrac
        $error("adder_tree_acc: frac must lie within the lane width");
    end
    if (AW > MAXW) begin : gBadWidth
        $error("adder_tree_acc: accumulator wider than the saturation helper");
    end

    logic [PADN*DWIDTH-1:0] paddedData;

    for (genvar i = 0; i < PADN; i++) begin : gPad
        if (i < NIN) begin : gLane
            assign paddedData[i*DWIDTH +: DWIDTH] = in_data[i*DWIDTH +: DWIDTH];
        end else begin : gZero
            assign paddedData[i*DWIDTH +: DWIDTH] = '0;
        end
    end

    // Each level halves the lane count and widens by one bit, so level L-1 yields one TW-bit sum.
    for (genvar k = 0; k < L; k++) begin : gLvl
        localparam int NI = PADN >> k;
        localparam int WI = DWIDTH + k;
        logic [NI*WI-1:0]         levelIn;
        logic                     validIn;
        logic                     lastIn;
        logic [(NI/2)*(WI+1)-1:0] levelOut;
        logic                     validOut;
        logic                     lastOut;

        if (k == 0) begin : gFirst
            assign levelIn = paddedData;
            assign validIn = in_valid;
            assign lastIn  = in_last & in_valid;
        end else begin : gNext
            assign levelIn = gLvl[k-1].levelOut;
            assign validIn = gLvl[k-1].validOut;
            assign lastIn  = gLvl[k-1].lastOut;
        end

        adder_level_pipe #(
            .NIN_LVL (NI),
            .W       (WI)
        ) uLevel (
            .clk     (clk),
            .rst     (rst),
            .valid_i (validIn),
            .last_i  (lastIn),
            .data_i  (levelIn),
            .valid_o (validOut),
            .last_o  (lastOut),
            .data_o  (levelOut)
        );
    end

    logic signed [TW-1:0]     treeSum;
    logic                     treeValid;
    logic                     treeLast;
    logic signed [AW-1:0]     accSum;
    logic signed [AW-1:0]     acc_q;
    logic [DWIDTH-1:0]        outData_d;
    logic                     outSat_d;
    logic [DWIDTH-1:0]        outData_q;
    logic                     outSat_q;
    logic                     outValid_q;

    assign treeSum   = gLvl[L-1].levelOut;
    assign treeValid = gLvl[L-1].validOut;
    assign treeLast  = gLvl[L-1].lastOut;

    always_comb begin
        outSat_d  = 1'b0;
        accSum    = acc_q + AW'(treeSum);
        outData_d = DWIDTH'(saturate(MAXW'(accSum), DWIDTH, SAT != 0, outSat_d));
    end

    // The last beat closes the packet and clears acc so the next beat starts a fresh sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outSat_q   <= 1'b0;
        end else begin
            outValid_q <= 1'b0;
            if (treeValid) begin
                if (treeLast) begin
                    acc_q      <= '0;
                    outValid_q <= 1'b1;
                    outData_q  <= outData_d;
                    outSat_q   <= outSat_d;
                end else begin
                    acc_q <= accSum;
                end
            end
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_sat   = outSat_q;

endmodule
